// File: rtl/mmio_uart_pkg.sv
// Shared definitions for the memory-mapped UART: register offsets, status bit
// positions and the TX/RX state encodings.
package mmio_uart_pkg;

    localparam logic [4:0] ADDR_TX   = 5'h00;
    localparam logic [4:0] ADDR_RX   = 5'h04;
    localparam logic [4:0] ADDR_CTRL = 5'h08;
    localparam logic [4:0] ADDR_STAT = 5'h10;

    localparam int unsigned STAT_TX_NFULL  = 0;
    localparam int unsigned STAT_RX_NEMPTY = 1;
    localparam int unsigned STAT_TX_DONE   = 2;
    localparam int unsigned STAT_OVERRUN   = 3;
    localparam int unsigned STAT_FRAME_ERR = 4;

    localparam int unsigned CTRL_RX_IE = 0;
    localparam int unsigned CTRL_TX_IE = 1;

    typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Byte-wide synchronous FIFO with fall-through head; a push is accepted while
// full when a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned AW = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [7:0]  wdata,
    input  logic        pop,
    output logic [7:0]  rdata,
    output logic        full,
    output logic        empty,
    output logic [AW:0] count
);

    localparam int unsigned Depth = 1 << AW;

    logic [7:0]  mem_q [Depth];
    logic [AW:0] wptr_q, rptr_q;
    logic        do_push, do_pop;

    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign count   = wptr_q - rptr_q;
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/mmio_uart_fifo.sv
// Memory-mapped UART with TX and RX byte FIFOs, registered 1-cycle read data
// and a level interrupt.
module mmio_uart_fifo
    import mmio_uart_pkg::*;
#(
    parameter int unsigned CLOCK_DIV = 104,
    parameter int unsigned FIFO_AW   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel,
    input  logic        mem_valid,
    input  logic        mem_write,
    input  logic [3:0]  mem_wmask,
    input  logic [31:0] mem_wdata,
    input  logic [4:0]  mem_addr,
    output logic [31:0] mem_rdata,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        irq
);

    localparam logic [15:0] DIV_M1  = 16'(CLOCK_DIV - 1);
    localparam logic [15:0] HALF_M1 = 16'(CLOCK_DIV / 2 - 1);

    // Bus decode
    logic req, rd_req, wr_req;
    logic tx_push, rx_pop, ctrl_wr, stat_wr;

    assign req     = sel & mem_valid;
    assign rd_req  = req & ~mem_write;
    assign wr_req  = req & mem_write;
    assign tx_push = wr_req & (mem_addr == ADDR_TX) & mem_wmask[0];
    assign ctrl_wr = wr_req & (mem_addr == ADDR_CTRL) & mem_wmask[0];
    assign stat_wr = wr_req & (mem_addr == ADDR_STAT) & mem_wmask[0];

    // FIFOs
    logic [7:0]       tx_head, rx_head, rx_byte;
    logic             tx_full, tx_empty, tx_pop;
    logic             rx_full, rx_empty, rx_push;
    logic [FIFO_AW:0] tx_count, rx_count;

    assign rx_pop = rd_req & (mem_addr == ADDR_RX) & ~rx_empty;

    sync_fifo #(.AW(FIFO_AW)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .wdata (mem_wdata[7:0]),
        .pop   (tx_pop),
        .rdata (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    sync_fifo #(.AW(FIFO_AW)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .wdata (rx_byte),
        .pop   (rx_pop),
        .rdata (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    // TX FSM
    tx_state_e   tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        tx_q, tx_d;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_d       = tx_q;
        tx_pop     = 1'b0;
        unique case (tx_state_q)
            TxIdle: begin
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = tx_head;
                    tx_d       = 1'b0;
                    tx_cnt_d   = DIV_M1;
                    tx_state_d = TxStart;
                end
            end
            TxStart: begin
                if (tx_cnt_q != '0) begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end else begin
                    tx_d       = tx_shift_q[0];
                    tx_bit_d   = '0;
                    tx_cnt_d   = DIV_M1;
                    tx_state_d = TxData;
                end
            end
            TxData: begin
                if (tx_cnt_q != '0) begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end else begin
                    tx_cnt_d = DIV_M1;
                    if (tx_bit_q == 3'd7) begin
                        tx_d       = 1'b1;
                        tx_state_d = TxStop;
                    end else begin
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_d       = tx_shift_q[1];
                        tx_bit_d   = tx_bit_q + 3'd1;
                    end
                end
            end
            TxStop: begin
                if (tx_cnt_q != '0) begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end else if (!tx_empty) begin
                    // Back-to-back frame: skip IDLE so no gap appears on the line.
                    tx_pop     = 1'b1;
                    tx_shift_d = tx_head;
                    tx_d       = 1'b0;
                    tx_cnt_d   = DIV_M1;
                    tx_state_d = TxStart;
                end else begin
                    tx_state_d = TxIdle;
                end
            end
            default: tx_state_d = TxIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= TxIdle;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
        end
    end

    assign uart_tx = tx_q;

    // RX synchronizer and FSM
    logic        rx_s1_q, rx_s2_q, rx_prev_q;
    rx_state_e   rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic        frame_set;

    assign rx_byte = rx_shift_q;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_push    = 1'b0;
        frame_set  = 1'b0;
        unique case (rx_state_q)
            RxIdle: begin
                // Needs a 1->0 transition, so a line held low after a bad stop never re-arms.
                if (!rx_s2_q && rx_prev_q) begin
                    rx_cnt_d   = HALF_M1;
                    rx_state_d = RxStart;
                end
            end
            RxStart: begin
                if (rx_cnt_q != '0) begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end else if (rx_s2_q) begin
                    rx_state_d = RxIdle;
                end else begin
                    rx_cnt_d   = DIV_M1;
                    rx_bit_d   = '0;
                    rx_state_d = RxData;
                end
            end
            RxData: begin
                if (rx_cnt_q != '0) begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end else begin
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                    rx_cnt_d   = DIV_M1;
                    if (rx_bit_q == 3'd7) rx_state_d = RxStop;
                    else                  rx_bit_d   = rx_bit_q + 3'd1;
                end
            end
            RxStop: begin
                if (rx_cnt_q != '0) begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end else begin
                    rx_state_d = RxIdle;
                    if (rx_s2_q) rx_push   = 1'b1;
                    else         frame_set = 1'b1;
                end
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RxIdle;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_s1_q    <= uart_rx;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    // Control, flags, read data
    logic        rx_ie_q, tx_ie_q;
    logic        overrun_q, overrun_d, frame_err_q, frame_err_d;
    logic [31:0] status, rd_val, rdata_q;

    always_comb begin
        overrun_d   = overrun_q;
        frame_err_d = frame_err_q;
        if (stat_wr && mem_wdata[STAT_OVERRUN])   overrun_d   = 1'b0;
        if (stat_wr && mem_wdata[STAT_FRAME_ERR]) frame_err_d = 1'b0;
        // A same-cycle bus pop frees the slot, so that case is not an overrun.
        if (rx_push && rx_full && !rx_pop)        overrun_d   = 1'b1;
        if (frame_set)                            frame_err_d = 1'b1;
    end

    always_comb begin
        status                 = '0;
        status[STAT_TX_NFULL]  = ~tx_full;
        status[STAT_RX_NEMPTY] = ~rx_empty;
        status[STAT_TX_DONE]   = tx_empty & (tx_state_q == TxIdle);
        status[STAT_OVERRUN]   = overrun_q;
        status[STAT_FRAME_ERR] = frame_err_q;
        status[15:8]           = 8'(rx_count);
    end

    always_comb begin
        rd_val = '0;
        case (mem_addr)
            ADDR_RX:   rd_val = rx_empty ? 32'd0 : {24'd0, rx_head};
            ADDR_CTRL: rd_val = {30'd0, tx_ie_q, rx_ie_q};
            ADDR_STAT: rd_val = status;
            default:   rd_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_ie_q     <= 1'b0;
            tx_ie_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            rdata_q     <= '0;
        end else begin
            if (ctrl_wr) begin
                rx_ie_q <= mem_wdata[CTRL_RX_IE];
                tx_ie_q <= mem_wdata[CTRL_TX_IE];
            end
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            if (rd_req) rdata_q <= rd_val;
        end
    end

    assign mem_rdata = rdata_q;
    assign irq       = (~rx_empty & rx_ie_q) | (tx_empty & tx_ie_q);

    logic unused_bits;
    assign unused_bits = ^{mem_wdata[31:8], mem_wmask[3:1], tx_count};

endmodule

// File: tb/tb_mmio_uart_fifo.sv
// Directed bench for mmio_uart_fifo at CLOCK_DIV=8: register access, TX frame
// timing, RX receive, FIFO limits, error flags and reset.
module tb_mmio_uart_fifo;

    localparam logic [4:0] A_TX = 5'h00, A_RX = 5'h04, A_CTRL = 5'h08, A_STAT = 5'h10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0, mem_valid = 1'b0, mem_write = 1'b0;
    logic [3:0]  mem_wmask = '0;
    logic [31:0] mem_wdata = '0;
    logic [4:0]  mem_addr = '0;
    logic [31:0] mem_rdata;
    logic        uart_rx = 1'b1;
    logic        uart_tx;
    logic        irq;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;

    logic [7:0] mon_bytes [$];
    int         mon_start [$];
    logic       mon_last = 1'b1;

    mmio_uart_fifo #(.CLOCK_DIV(8), .FIFO_AW(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .sel       (sel),
        .mem_valid (mem_valid),
        .mem_write (mem_write),
        .mem_wmask (mem_wmask),
        .mem_wdata (mem_wdata),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .uart_rx   (uart_rx),
        .uart_tx   (uart_tx),
        .irq       (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] m);
        @(negedge clk);
        sel = 1'b1; mem_valid = 1'b1; mem_write = 1'b1;
        mem_addr = a; mem_wdata = d; mem_wmask = m;
        @(negedge clk);
        sel = 1'b0; mem_valid = 1'b0; mem_write = 1'b0; mem_wmask = '0;
    endtask

    task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; mem_valid = 1'b1; mem_write = 1'b0; mem_addr = a; mem_wmask = '0;
        @(negedge clk);
        sel = 1'b0; mem_valid = 1'b0;
        d = mem_rdata;
    endtask

    // 8 clocks per bit, start, 8 data LSB first, then the given stop level.
    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk) uart_rx = 1'b0;
        repeat (7) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk) uart_rx = b[i];
            repeat (7) @(negedge clk);
        end
        @(negedge clk) uart_rx = stop;
        repeat (7) @(negedge clk);
        @(negedge clk) uart_rx = 1'b1;
    endtask

    // Line monitor: decodes TX frames at mid-bit and records each start cycle.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (uart_tx === 1'b0 && mon_last === 1'b1) begin
                mon_start.push_back(cyc);
                b = '0;
                repeat (4) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (8) @(negedge clk);
                    b[i] = uart_tx;
                end
                repeat (8) @(negedge clk);
                mon_bytes.push_back(b);
                repeat (3) @(negedge clk);
            end
            mon_last = uart_tx;
        end
    end

    initial begin
        logic [31:0] rd;
        logic [7:0]  samp;
        logic        bit_exp;
        int          guard, bad;

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
        check("rst_rdata", mem_rdata, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        bus_read(A_STAT, rd);
        check("rst_status", rd, 32'h05);

        // Single 0x55 frame, bit-exact timing
        bus_write(A_TX, 32'h55, 4'b0001);
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < 8; j++) begin
                @(negedge clk);
                samp[j] = uart_tx;
            end
            if (k == 0)      bit_exp = 1'b0;
            else if (k == 9) bit_exp = 1'b1;
            else             bit_exp = (k % 2) == 1;
            check($sformatf("tx55_period%0d", k), {24'd0, samp}, bit_exp ? 32'hFF : 32'h00);
        end
        bus_read(A_STAT, rd);
        check("tx55_status_done", rd, 32'h05);

        // Burst of 9 writes: first is popped at once, so all 9 fit; a 10th while full is lost
        repeat (5) @(negedge clk);
        mon_bytes.delete();
        mon_start.delete();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            sel = 1'b1; mem_valid = 1'b1; mem_write = 1'b1;
            mem_addr = A_TX; mem_wdata = 32'(i + 1); mem_wmask = 4'b0001;
        end
        bus_read(A_STAT, rd);
        check("tx_full_status", rd, 32'h00);
        guard = 0;
        while (mon_bytes.size() < 9 && guard < 1500) begin
            @(negedge clk);
            guard++;
        end
        repeat (20) @(negedge clk);
        check("tx_frame_count", 32'(mon_bytes.size()), 32'd9);
        for (int i = 0; i < 9 && i < mon_bytes.size(); i++)
            check($sformatf("tx_frame%0d", i), {24'd0, mon_bytes[i]}, 32'(i + 1));
        bad = 0;
        for (int i = 1; i < mon_start.size(); i++)
            if (mon_start[i] - mon_start[i-1] != 80) bad++;
        check("tx_no_gap", 32'(bad), 32'd0);
        bus_read(A_STAT, rd);
        check("tx_burst_done", rd, 32'h05);

        // RX single byte with rx_ie
        bus_write(A_CTRL, 32'h1, 4'b0001);
        bus_read(A_CTRL, rd);
        check("ctrl_read", rd, 32'h1);
        bus_write(A_STAT, 32'h18, 4'b0000);
        check("rdata_hold", mem_rdata, 32'h1);
        check("irq_before_rx", {31'd0, irq}, 32'd0);
        send_byte(8'hA3, 1'b1);
        check("irq_after_rx", {31'd0, irq}, 32'd1);
        bus_read(A_STAT, rd);
        check("rx_status_one", rd, 32'h107);
        bus_read(A_RX, rd);
        check("rx_data_a3", rd, 32'hA3);
        check("irq_after_pop", {31'd0, irq}, 32'd0);
        bus_read(A_STAT, rd);
        check("rx_status_empty", rd, 32'h05);
        bus_read(A_RX, rd);
        check("rx_empty_read", rd, 32'h0);

        // Overrun: nine frames into an 8-deep FIFO
        for (int i = 0; i < 9; i++) send_byte(8'(8'h10 + i), 1'b1);
        bus_read(A_STAT, rd);
        check("ovr_status", rd, 32'h080F);
        for (int i = 0; i < 8; i++) begin
            bus_read(A_RX, rd);
            check($sformatf("ovr_data%0d", i), rd, 32'(8'h10 + i));
        end
        bus_write(A_STAT, 32'h08, 4'b0001);
        bus_read(A_STAT, rd);
        check("ovr_cleared", rd, 32'h05);

        // Frame error, then clear
        send_byte(8'h5A, 1'b0);
        repeat (10) @(negedge clk);
        bus_read(A_STAT, rd);
        check("frame_err_status", rd, 32'h15);
        bus_write(A_STAT, 32'h10, 4'b0001);
        bus_read(A_STAT, rd);
        check("frame_err_cleared", rd, 32'h05);

        // Two-cycle glitch on idle line
        @(negedge clk) uart_rx = 1'b0;
        repeat (2) @(negedge clk);
        uart_rx = 1'b1;
        repeat (100) @(negedge clk);
        bus_read(A_STAT, rd);
        check("glitch_status", rd, 32'h05);

        // tx_ie interrupt, then reset mid TX frame
        bus_write(A_CTRL, 32'h2, 4'b0001);
        check("irq_tx_empty", {31'd0, irq}, 32'd1);
        bus_write(A_TX, 32'h00, 4'b0001);
        repeat (30) @(negedge clk);
        check("tx_mid_frame_low", {31'd0, uart_tx}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_uart_tx", {31'd0, uart_tx}, 32'd1);
        check("rst_mid_irq", {31'd0, irq}, 32'd0);
        rst = 1'b0;
        bus_read(A_STAT, rd);
        check("rst_mid_status", rd, 32'h05);
        bus_read(A_CTRL, rd);
        check("rst_mid_ctrl", rd, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mmio_uart_fifo.md
Name: mmio_uart_fifo

Overview:
- Memory-mapped UART peripheral on the core data bus, replacing the inline UART logic in the SoC top.
- Buffers TX bytes and RX bytes in two synchronous FIFOs, so software does not poll once per character.
- Keeps the existing register map (TX at +0, RX at +4, status at +16) and the registered, 1-cycle read latency.

Parameters:
- CLOCK_DIV, 104, clock cycles per UART bit; legal range 4..65535.
- FIFO_AW, 3, log2 of depth for each FIFO (default 8 entries).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- sel  in  1  address decode hit for this peripheral, qualifies mem_valid.
- mem_valid  in  1  bus request.
- mem_write  in  1  1 = write, 0 = read.
- mem_wmask  in  4  byte enables.
- mem_wdata  in  32  write data.
- mem_addr  in  5  byte offset within the peripheral.
- mem_rdata  out  32  read data, valid the cycle after the request.
- uart_rx  in  1  serial input, asynchronous.
- uart_tx  out  1  serial output, idle high.
- irq  out  1  level interrupt: (RX not empty & rx_ie) | (TX empty & tx_ie).

Behaviour:
- Reset:
  - uart_tx=1, mem_rdata=0, irq=0.
  - Both FIFOs empty; rx_ie=0, tx_ie=0.
  - overrun=0, frame_err=0; RX and TX FSMs in IDLE.
- Access is req = sel & mem_valid.
- Register map:
  - +0 TX write: if mem_wmask[0], push wdata[7:0]. If the TX FIFO is full the byte is dropped and no flag is set. Reads return 0.
  - +4 RX read: returns {24'b0, head byte} and pops. Reading an empty FIFO returns 0 with no pop. Writes are ignored.
  - +8 CTRL R/W: bit0 rx_ie, bit1 tx_ie; the write requires mem_wmask[0].
  - +16 STATUS read: bit0 = TX not full, bit1 = RX not empty, bit2 = TX FIFO empty & TX FSM idle, bit3 = overrun, bit4 = frame_err, bits[15:8] = RX count. Any write to +16 with mem_wmask[0] clears the flags whose wdata bit is 1 (bit3, bit4).
  - Any other offset reads 0.
- Read timing:
  - mem_rdata is registered; the value for a read in cycle N appears in N+1.
  - mem_rdata holds until the next read req.
  - The pop happens in cycle N.
- Simultaneous events:
  - A push and the TX FSM's pop in the same cycle are both honoured, including when the FIFO is full.
  - An RX receive push and a bus pop in the same cycle are both honoured. If the FIFO is full, the pop frees a slot and the new byte is stored with no overrun.
- TX FSM: IDLE -> START -> DATA(8) -> STOP -> IDLE.
  - IDLE: if the FIFO is not empty, pop the byte, drive 0 and enter START.
  - Each state lasts exactly CLOCK_DIV cycles. Data goes out LSB first; STOP drives 1.
  - From STOP, if the FIFO is not empty, go directly to START (back-to-back frames, no idle gap).
- RX input: uart_rx passes through a 2-flop synchronizer.
- RX FSM: IDLE -> START -> DATA -> STOP.
  - IDLE: a falling edge (synced 0 while the previous synced value was 1) loads the counter with CLOCK_DIV/2 - 1.
  - START: at the mid-bit sample, if the line is 1 the start is false: return to IDLE, no push.
  - DATA: 8 samples taken CLOCK_DIV apart, LSB first.
  - STOP: sampled once. If 0, set frame_err, discard the byte, and wait in IDLE for the line to return to 1 before re-arming. If 1, push the byte; if the FIFO is full, set overrun and drop the new byte (old contents are kept).
- Reset asserted mid-frame:
  - TX aborts and uart_tx goes to 1 on the next edge.
  - RX aborts; FIFO contents are lost.
- Counter widths: 16-bit baud counters; FIFO pointers FIFO_AW+1 bits with wrap-around. Full = MSBs differ and low bits equal.

Decomposition:
- Package mmio_uart_pkg holds the register offsets (TX=0, RX=4, CTRL=8, STAT=16), the status bit indices and the FSM state encodings.
- One reusable sub-module, sync_fifo: 8-bit wide, parameter AW, push/pop/full/empty/count, same-cycle push+pop allowed when full. It is instantiated twice, for TX and RX.
- Target size: top ~200 lines, FIFO ~60 lines.

Test Plan (all scenarios use CLOCK_DIV=8):
- Reset, then read +16 -> mem_rdata=0x00000005 one cycle later; uart_tx=1.
- Write 0x55 to +0 -> uart_tx low for 8 cycles, then 1,0,1,0,1,0,1,0 at 8 cycles each, then high for 8 cycles. STATUS bit2=1 after the stop bit ends.
- Write 9 bytes 0x01..0x09 back-to-back -> the 9th is accepted only if the TX FSM has popped one byte. Otherwise it is dropped: 8 frames are observed with no idle gap, and STATUS bit0=0 while full.
- Drive 0xA3 serially on uart_rx -> STATUS bit1=1 and count=1; read +4 -> 0x000000A3, then STATUS count=0. Set rx_ie first and check irq rises after the stop bit and falls after the pop.
- Send 9 frames without reading -> overrun=1 and count=8; reads return the first 8 bytes. Write 0x08 to +16 -> overrun=0.
- Stop bit driven 0 -> frame_err=1 and no push. A 2-cycle low glitch on idle uart_rx -> no push, no flags. Assert rst mid-TX-frame -> uart_tx=1 the next cycle and STATUS=0x05.
